// File: rtl/restoring_divider_8_bit_pkg.sv
// Shared encodings and constants for the 8-bit restoring divider.
// Imported by the divider top and its trial subtractor.
package restoring_divider_8_bit_pkg;

  localparam int DIV_WIDTH = 8;
  localparam logic [DIV_WIDTH-1:0] DBZ_QUOTIENT = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/r_c_8_bit_subtractor.sv
// Ripple-borrow 8-bit subtractor: d = x - y - z, b is the borrow out of the MSB.
// The divider uses b as its restore select.
module r_c_8_bit_subtractor
  import restoring_divider_8_bit_pkg::*;
(
  input  logic [DIV_WIDTH-1:0] x,
  input  logic [DIV_WIDTH-1:0] y,
  input  logic                 z,
  output logic [DIV_WIDTH-1:0] d,
  output logic                 b
);

  logic [DIV_WIDTH:0] borrowChain;

  // Each stage borrows when y plus the incoming borrow exceeds x.
  always_comb begin
    borrowChain    = '0;
    d              = '0;
    borrowChain[0] = z;
    for (int i = 0; i < DIV_WIDTH; i++) begin
      d[i]             = x[i] ^ y[i] ^ borrowChain[i];
      borrowChain[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & borrowChain[i]);
    end
    b = borrowChain[DIV_WIDTH];
  end

endmodule

// File: rtl/restoring_divider_8_bit.sv
// Sequential unsigned restoring divider producing one quotient bit per clock,
// with a start/busy/done handshake and divide-by-zero reporting.
module restoring_divider_8_bit
  import restoring_divider_8_bit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  state_e           state_q;
  logic [2:0]       count_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] divisor_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             dbz_q;

  logic [WIDTH-1:0] trialValue;
  logic [WIDTH-1:0] trialDiff;
  logic             trialBorrow;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] q_d;

  // The partial remainder stays below 2^i before step i, so the shifted value
  // always fits in WIDTH bits and the borrow alone decides the quotient bit.
  assign trialValue = {rem_q[WIDTH-2:0], q_q[WIDTH-1]};

  r_c_8_bit_subtractor trialSub (
    .x (trialValue),
    .y (divisor_q),
    .z (1'b0),
    .d (trialDiff),
    .b (trialBorrow)
  );

  always_comb begin
    rem_d = trialBorrow ? trialValue : trialDiff;
    q_d   = {q_q[WIDTH-2:0], ~trialBorrow};
  end

  // Start is only honoured in IDLE or DONE, which lets back-to-back requests
  // chain without a dead cycle; published results move only on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      rem_q       <= '0;
      q_q         <= '0;
      divisor_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            divisor_q <= divisor;
            rem_q     <= '0;
            q_q       <= dividend;
            count_q   <= '0;
            dbz_q     <= 1'b0;
            if (divisor != '0) begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
            end else begin
              state_q     <= ST_DONE;
              done_q      <= 1'b1;
              quotient_q  <= DBZ_QUOTIENT;
              remainder_q <= dividend;
              dbz_q       <= 1'b1;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          rem_q   <= rem_d;
          q_q     <= q_d;
          count_q <= count_q + 3'd1;
          if (count_q == 3'd7) begin
            state_q     <= ST_DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            quotient_q  <= q_d;
            remainder_q <= rem_d;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider_8_bit.sv
// Scoreboard testbench for restoring_divider_8_bit: stimulus pushes expected
// results, a monitor pops and compares on every done pulse.
module tb_restoring_divider_8_bit;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] dividend = '0;
  logic [7:0] divisor = '0;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  exp_t sb[$];
  int   tests = 0;
  int   failed = 0;

  restoring_divider_8_bit dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      tests++;
      if (sb.size() == 0) begin
        failed++;
        $display("[TB] FAIL unexpected_done: got q=%0d r=%0d dbz=%0d, expected no done",
                 quotient, remainder, div_by_zero);
      end else begin
        e = sb.pop_front();
        if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dbz) begin
          failed++;
          $display("[TB] FAIL result: got q=%0d r=%0d dbz=%0d, expected q=%0d r=%0d dbz=%0d",
                   quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
        end
      end
    end
  end

  task automatic pushExpect(input logic [7:0] q, input logic [7:0] r, input logic dbz);
    exp_t e;
    e.q = q;
    e.r = r;
    e.dbz = dbz;
    sb.push_back(e);
  endtask

  // Drives one single-cycle start pulse; returns at the negedge after acceptance.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] eq, input logic [7:0] er,
                               input logic edbz, input bit doPush);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    if (doPush) pushExpect(eq, er, edbz);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts negedges until done is visible, with a bound against hangs.
  task automatic waitDone(input string name, output int n, output int busyCnt);
    n = 0;
    busyCnt = 0;
    while (!done && n < 30) begin
      if (busy) busyCnt++;
      @(negedge clk);
      n++;
    end
    if (!done) begin
      tests++;
      failed++;
      $display("[TB] FAIL %s_timeout: got no done after %0d cycles, expected done", name, n);
    end
  endtask

  initial begin
    int n;
    int bc;
    logic [7:0] vals [10];
    vals = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd7, 8'd100, 8'd127, 8'd128, 8'd254, 8'd255};

    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_quotient", quotient, 0);
    checkOutput("reset_remainder", remainder, 0);
    checkOutput("reset_dbz", div_by_zero, 0);

    applyStimulus(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b1);
    waitDone("basic", n, bc);
    checkOutput("basic_latency", n, 8);
    checkOutput("basic_busy_cycles", bc, 8);
    @(negedge clk);
    checkOutput("done_one_cycle", done, 0);

    applyStimulus(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 1'b1);
    waitDone("div255_1", n, bc);
    applyStimulus(8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 1'b1);
    waitDone("div255_255", n, bc);
    applyStimulus(8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 1'b1);
    waitDone("div5_9", n, bc);
    checkOutput("hold_quotient", quotient, 0);

    applyStimulus(8'd200, 8'd0, 8'hFF, 8'd200, 1'b1, 1'b1);
    waitDone("dbz", n, bc);
    checkOutput("dbz_latency", n, 0);
    checkOutput("dbz_busy_cycles", bc, 0);
    applyStimulus(8'd10, 8'd3, 8'd3, 8'd1, 1'b0, 1'b1);
    waitDone("after_dbz", n, bc);

    applyStimulus(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    dividend = 8'd50;
    divisor  = 8'd5;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone("ignore_start", n, bc);
    checkOutput("ignore_start_latency", n, 5);

    applyStimulus(8'd100, 8'd7, 8'd0, 8'd0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_quotient", quotient, 0);
    checkOutput("abort_remainder", remainder, 0);
    repeat (12) @(negedge clk);
    applyStimulus(8'd9, 8'd2, 8'd4, 8'd1, 1'b0, 1'b1);
    waitDone("after_abort", n, bc);

    @(negedge clk);
    dividend = 8'd77;
    divisor  = 8'd6;
    start    = 1'b1;
    pushExpect(8'd12, 8'd5, 1'b0);
    @(negedge clk);
    waitDone("b2b_first", n, bc);
    dividend = 8'd200;
    divisor  = 8'd13;
    pushExpect(8'd15, 8'd5, 1'b0);
    @(negedge clk);
    start = 1'b0;
    waitDone("b2b_second", n, bc);
    checkOutput("b2b_gap", n + 1, 9);

    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < 10; j++) begin
        logic [7:0] a;
        logic [7:0] b;
        a = vals[i];
        b = vals[j];
        if (b == 0) applyStimulus(a, b, 8'hFF, a, 1'b1, 1'b1);
        else applyStimulus(a, b, a / b, a % b, 1'b0, 1'b1);
        waitDone("sweep", n, bc);
        checkOutput("sweep_latency", n, (b == 0) ? 0 : 8);
      end
    end

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
